digit_scan_controller: RTL and testbench

Time-multiplexed scan controller for the four-digit display. It produces the 2-bit digit select consumed by the one-hot digit decoder (`Switcher`), gates the digit drive, and presents the nibble for the active digit. It also double-buffers display data so that updates take effect only on a frame boundary.

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_prescaler.sv | 29 ++
 rtl/digit_scan_controller.sv | 118 +++++++++++
 tb/tb_digit_scan_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the four-digit scan controller.
package scan_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam int DIGITS = 4;
  localparam int SEL_W  = 2;
  localparam int NIB_W  = 4;

  // Prescaler counter width for a modulo-div counter (div >= 2).
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV slot counter. slot_end marks the last cycle of a slot,
// blank_start marks the cycle after which the dead time begins.
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 4
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic blank_start
);

  localparam int CW = presc_width(DIV);

  logic [CW-1:0] cnt;

  assign slot_end    = (cnt == CW'(DIV - 1));
  assign blank_start = (cnt == CW'(DIV - BLANK - 1));

  // Free-running count 0..DIV-1, wrapping on the last cycle of the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (slot_end) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/digit_scan_controller.sv
// Four-digit time-multiplexed scan controller with frame-aligned double
// buffering of display data. Optional dead time before each digit change
// is compiled in with SCAN_BLANK_EN.
module digit_scan_controller
  import scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DIGITS*NIB_W-1:0]   DIN,
  input  logic [DIGITS-1:0]         MASK,
  input  logic                      LOAD,
  output logic [SEL_W-1:0]          SEL,
  output logic                      EN,
  output logic [NIB_W-1:0]          NIB,
  output logic                      FRAME,
  output logic                      LOAD_ACK
);

  logic slot_end, blank_start;

  scan_prescaler #(.DIV(DIV), .BLANK(BLANK)) u_presc (
    .clk        (CLK),
    .rst        (RST),
    .slot_end   (slot_end),
    .blank_start(blank_start)
  );

  state_t                    state, state_d;
  logic [DIGITS*NIB_W-1:0]   act_din, pend_din, act_din_d;
  logic [DIGITS-1:0]         act_mask, pend_mask, act_mask_d;
  logic                      pend_flag;
  logic [SEL_W-1:0]          sel_d;
  logic                      boundary, apply;
  logic                      en_d;
  logic [NIB_W-1:0]          nib_d;

  // Outputs are registered from the next-cycle values so SEL, EN, NIB and
  // LOAD_ACK stay mutually consistent in the same cycle.
  assign sel_d      = slot_end ? SEL + 1'b1 : SEL;
  assign boundary   = slot_end && (SEL == SEL_W'(DIGITS - 1));
  assign apply      = boundary && pend_flag;
  assign act_din_d  = apply ? pend_din  : act_din;
  assign act_mask_d = apply ? pend_mask : act_mask;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_SHOW;
    else     state <= state_d;
  end

  // Next state: dead time starts BLANK cycles before the slot wrap.
`ifdef SCAN_BLANK_EN
  always_comb begin
    state_d = state;
    if (slot_end)         state_d = ST_SHOW;
    else if (blank_start) state_d = ST_BLANK;
  end
`else
  // Without blanking the machine never leaves SHOW, so the blank strobe
  // has no consumer.
  logic blank_unused;
  assign blank_unused = blank_start;

  always_comb begin
    state_d = state;
  end
`endif

  // Output decode for the upcoming cycle.
  always_comb begin
    en_d  = act_mask_d[sel_d] && (state_d == ST_SHOW);
    nib_d = act_din_d[sel_d*NIB_W +: NIB_W];
  end

  // Registered display outputs and frame/ack strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL      <= '0;
      EN       <= 1'b0;
      NIB      <= '0;
      FRAME    <= 1'b0;
      LOAD_ACK <= 1'b0;
    end else begin
      SEL      <= sel_d;
      EN       <= en_d;
      NIB      <= nib_d;
      FRAME    <= boundary;
      LOAD_ACK <= apply;
    end
  end

  // Double buffer: a LOAD always lands in pending (latest wins); pending
  // moves to active only on the 3->0 boundary. A LOAD on the boundary edge
  // itself refills pending and waits a full frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_din  <= '0;
      pend_mask <= '0;
      pend_flag <= 1'b0;
      act_din   <= '0;
      act_mask  <= '0;
    end else begin
      act_din  <= act_din_d;
      act_mask <= act_mask_d;
      if (LOAD) begin
        pend_din  <= DIN;
        pend_mask <= MASK;
        pend_flag <= 1'b1;
      end else if (apply) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_controller.sv
// Directed bench for digit_scan_controller with DIV=8, BLANK=2.
// Cycle c = number of rising edges since reset release; sampled 1ns after.
module tb_digit_scan_controller;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DIN = '0;
  logic [3:0]  MASK = '0;
  logic        LOAD = 1'b0;
  logic [1:0]  SEL;
  logic        EN;
  logic [3:0]  NIB;
  logic        FRAME;
  logic        LOAD_ACK;

  int n_chk  = 0;
  int n_fail = 0;
  int c      = 0;

  digit_scan_controller #(.DIV(DIV), .BLANK(BLANK)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .MASK    (MASK),
    .LOAD    (LOAD),
    .SEL     (SEL),
    .EN      (EN),
    .NIB     (NIB),
    .FRAME   (FRAME),
    .LOAD_ACK(LOAD_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, c, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    c++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"},   16'(SEL),      16'h0);
    check({tag, "_en"},    16'(EN),       16'h0);
    check({tag, "_nib"},   16'(NIB),      16'h0);
    check({tag, "_frame"}, 16'(FRAME),    16'h0);
    check({tag, "_ack"},   16'(LOAD_ACK), 16'h0);
  endtask

  // Advance to cycle 'stop', checking every cycle against the given active
  // display contents; LOAD_ACK is expected exactly at cycle ack_at.
  task automatic run_to(input int stop, input logic [15:0] din,
                        input logic [3:0] mask, input int ack_at);
    int   s, p;
    logic en;
    while (c < stop) begin
      step();
      s = (c / DIV) % 4;
      p = c % DIV;
`ifdef SCAN_BLANK_EN
      en = mask[s] && (p < DIV - BLANK);
`else
      en = mask[s];
`endif
      check("sel",   16'(SEL),      16'(s));
      check("en",    16'(EN),       16'(en));
      check("nib",   16'(NIB),      16'((din >> (4 * s)) & 16'hF));
      check("frame", 16'(FRAME),    16'(p == 0 && s == 0));
      check("ack",   16'(LOAD_ACK), 16'(c == ack_at));
    end
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    LOAD = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("rst");
    RST = 1'b0;
    c   = 0;
  endtask

  initial begin
    // No load: SEL walks 0..3, display dark, first FRAME at 32.
    do_reset();
    run_to(40, 16'h0, 4'h0, -1);

    // Load 4321/F mid-frame: ack with FRAME at 32, then digits 1,2,3,4.
    do_reset();
    run_to(5, 16'h0, 4'h0, -1);
    DIN = 16'h4321; MASK = 4'hF; LOAD = 1'b1;
    run_to(6, 16'h0, 4'h0, -1);
    LOAD = 1'b0; DIN = '0; MASK = '0;
    run_to(31, 16'h0, 4'h0, -1);
    run_to(40, 16'h4321, 4'hF, 32);

    // Mask 0101: only digits 0 and 2 light, SEL still visits 1 and 3.
    DIN = 16'h4321; MASK = 4'b0101; LOAD = 1'b1;
    run_to(41, 16'h4321, 4'hF, -1);
    LOAD = 1'b0;
    run_to(63, 16'h4321, 4'hF, -1);
    run_to(70, 16'h4321, 4'h5, 64);

    // Two loads in one frame: latest wins, single ack at 96.
    DIN = 16'h1111; MASK = 4'hF; LOAD = 1'b1;
    run_to(71, 16'h4321, 4'h5, -1);
    LOAD = 1'b0;
    run_to(80, 16'h4321, 4'h5, -1);
    DIN = 16'h2222; MASK = 4'hF; LOAD = 1'b1;
    run_to(81, 16'h4321, 4'h5, -1);
    LOAD = 1'b0;
    run_to(95, 16'h4321, 4'h5, -1);
    run_to(127, 16'h2222, 4'hF, 96);

    // Load on the boundary edge (edge 128): deferred to the boundary at 160.
    DIN = 16'h5678; MASK = 4'hF; LOAD = 1'b1;
    run_to(128, 16'h2222, 4'hF, -1);
    LOAD = 1'b0;
    run_to(159, 16'h2222, 4'hF, -1);
    run_to(165, 16'h5678, 4'hF, 160);

    // Pending load then async reset mid slot 2: load is lost.
    DIN = 16'h9999; MASK = 4'hF; LOAD = 1'b1;
    run_to(166, 16'h5678, 4'hF, -1);
    LOAD = 1'b0;
    run_to(178, 16'h5678, 4'hF, -1);
    #2;
    RST = 1'b1;
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    c   = 0;
    run_to(40, 16'h0, 4'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
